// File: rtl/mmc3_scanline_irq.sv
// mmc3_scanline_irq
//   MMC3-style scanline IRQ generator. PPU A12 is synchronised into the m2
//   domain, rising edges that follow a long enough low gap become a single
//   scanline clock (clk_scan), which steps a reloadable down-counter. When the
//   counter reaches zero with IRQs enabled, the active-low irq line is pulled.
//
//   Optional feature macro: MMC3_IRQ_REV_A_EN
//     defined   : Rev A behaviour, a reload of 0 from a zero counter does not fire.
//     undefined : Rev B/Sharp behaviour, any step landing on 0 fires.
//
// Ports
//   m2          in   CPU M2, sole clock (posedge)
//   reset       in   asynchronous, active-high
//   enable      in   mapper selects MMC3 IRQ; 0 freezes state and holds irq high
//   romsel      in   active-low $8000-$FFFF select
//   cpu_rw_in   in   1 = read, 0 = write
//   cpu_addr_in in   CPU A14..A0
//   cpu_data_in in   CPU data bus
//   ppu_a12     in   PPU A12, asynchronous to m2
//   irq         out  active-low IRQ request, 1 = idle
module mmc3_scanline_irq #(
    parameter int A12_LOW_MIN  = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int COUNTER_BITS = 8
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        enable,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    output logic        irq
);
    localparam int LCW = $clog2(A12_LOW_MIN + 1);

    typedef struct packed {
        logic c000;
        logic c001;
        logic e000;
        logic e001;
    } wr_t;

    logic [SYNC_STAGES-1:0]  a12_sync;
    logic                    a12_s;
    logic [LCW-1:0]          low_cnt;
    logic                    clk_scan;
    logic                    scan;
    wr_t                     wr;
    logic                    wr_strobe;
    logic [COUNTER_BITS-1:0] latch;
    logic [COUNTER_BITS-1:0] counter;
    logic [COUNTER_BITS-1:0] step_val;
    logic                    reload_flag;
    logic                    irq_enabled;
    logic                    irq_pending;
    logic                    fire;
    logic                    unused_addr;

    // Only A14, A13 and A0 take part in the register decode.
    assign unused_addr = ^cpu_addr_in[12:1];

    // ---------------- A12 synchroniser and edge filter ----------------
    assign a12_s = a12_sync[SYNC_STAGES-1];

    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            a12_sync <= '0;
            low_cnt  <= '0;
        end else begin
            a12_sync <= {a12_sync[SYNC_STAGES-2:0], ppu_a12};
            if (a12_s)
                low_cnt <= '0;
            else if (low_cnt != LCW'(A12_LOW_MIN))
                low_cnt <= low_cnt + 1'b1;
        end
    end

    // low_cnt is non-zero only if the previous a12_s sample was 0, so a
    // saturated count with a12_s high is exactly a qualified 0->1 transition.
    assign clk_scan = a12_s & (low_cnt == LCW'(A12_LOW_MIN));
    assign scan     = clk_scan & enable;

    // ---------------- CPU register decode ----------------
    assign wr_strobe = enable & ~romsel & ~cpu_rw_in & cpu_addr_in[14];

    always_comb begin
        wr      = '0;
        wr.c000 = wr_strobe & ~cpu_addr_in[13] & ~cpu_addr_in[0];
        wr.c001 = wr_strobe & ~cpu_addr_in[13] &  cpu_addr_in[0];
        wr.e000 = wr_strobe &  cpu_addr_in[13] & ~cpu_addr_in[0];
        wr.e001 = wr_strobe &  cpu_addr_in[13] &  cpu_addr_in[0];
    end

    // ---------------- Counter step and IRQ condition ----------------
    assign step_val = (counter == '0 || reload_flag) ? latch : counter - 1'b1;

`ifdef MMC3_IRQ_REV_A_EN
    // Reloading 0 into an already-zero counter is not a new terminal count.
    assign fire = scan & irq_enabled & (step_val == '0) & ((counter != '0) | reload_flag);
`else
    assign fire = scan & irq_enabled & (step_val == '0);
`endif

    // Later assignments win: a $C001 overrides the same-edge counter step,
    // a $E000 overrides the same-edge IRQ set. All decisions use old state.
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            latch       <= '0;
            counter     <= '0;
            reload_flag <= 1'b0;
            irq_enabled <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (scan) begin
                counter     <= step_val;
                reload_flag <= 1'b0;
            end
            if (wr.c001) begin
                counter     <= '0;
                reload_flag <= 1'b1;
            end
            if (wr.c000)
                latch <= COUNTER_BITS'(cpu_data_in);
            if (wr.e001)
                irq_enabled <= 1'b1;
            if (wr.e000)
                irq_enabled <= 1'b0;
            if (fire)
                irq_pending <= 1'b1;
            if (wr.e000)
                irq_pending <= 1'b0;
        end
    end

    assign irq = ~(irq_pending & enable);

endmodule
